// File: rtl/divider_channel_arbiter.sv
// Shares one serial fraction divider between CHANNELS requesters.
// Define DIV_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration.
module divider_channel_arbiter #(
    parameter int CHANNELS     = 2,
    parameter int OPERAND_BITS = 30,
    parameter int RESULT_BITS  = 25
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             CE,
    input  logic [CHANNELS-1:0]              REQ,
    input  logic [CHANNELS*OPERAND_BITS-1:0] REQ_A,
    input  logic [CHANNELS*OPERAND_BITS-1:0] REQ_B,
    output logic [CHANNELS-1:0]              ACK,
    output logic                             RES_VALID,
    output logic [$clog2(CHANNELS)-1:0]      RES_CH,
    output logic [RESULT_BITS-1:0]           RES_DATA,
    output logic                             DIV_CE,
    output logic [OPERAND_BITS-1:0]          DIV_A,
    output logic [OPERAND_BITS-1:0]          DIV_B,
    input  logic                             DIV_IN_READY,
    input  logic                             DIV_RES_READY,
    input  logic [RESULT_BITS-1:0]           DIV_RESULT
);

    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0]     r_ack;
    logic                    r_res_valid;
    logic [CW-1:0]           r_res_ch;
    logic [RESULT_BITS-1:0]  r_res_data;
    logic [OPERAND_BITS-1:0] r_div_a;
    logic [OPERAND_BITS-1:0] r_div_b;
    logic                    r_stg_valid;
    logic [CW-1:0]           r_stg_ch;
    logic                    r_inf_valid;
    logic [CW-1:0]           r_inf_ch;
    logic                    r_pend_valid;
    logic [CW-1:0]           r_pend_ch;

    logic                    w_slot;
    logic [CHANNELS-1:0]     w_elig;
    logic                    w_found;
    logic [CW-1:0]           w_win;
    logic                    w_load;
    logic [CHANNELS-1:0]     w_grant;
    logic [OPERAND_BITS-1:0] w_a;
    logic [OPERAND_BITS-1:0] w_b;

    assign w_slot = DIV_IN_READY & CE;
    // A channel being acknowledged this cycle must not be captured twice
    assign w_elig = REQ & ~r_ack;

`ifdef DIV_ARB_FIXED_PRIORITY_EN
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_found = 1'b1;
                w_win   = CW'(i);
            end
        end
    end
`else
    localparam int IW = CW + 1;

    logic [CW-1:0]           r_ptr;
    logic [2*CHANNELS-1:0]   w_elig2;
    logic [IW-1:0]           w_idx;

    assign w_elig2 = {w_elig, w_elig};

    // Descending scan so the nearest channel after r_ptr wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            w_idx = {1'b0, r_ptr} + IW'(k);
            if (w_elig2[w_idx]) begin
                w_found = 1'b1;
                w_win   = (w_idx >= IW'(CHANNELS))
                        ? CW'(w_idx - IW'(CHANNELS))
                        : CW'(w_idx);
            end
        end
    end
`endif

    assign w_load  = CE & (~r_stg_valid | w_slot) & w_found;
    assign w_grant = CHANNELS'(1) << w_win;

    always_comb begin
        w_a = REQ_A[w_win*OPERAND_BITS +: OPERAND_BITS];
        w_b = REQ_B[w_win*OPERAND_BITS +: OPERAND_BITS];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ack        <= '0;
            r_res_valid  <= 1'b0;
            r_res_ch     <= '0;
            r_res_data   <= '0;
            r_div_a      <= '0;
            r_div_b      <= '1;
            r_stg_valid  <= 1'b0;
            r_stg_ch     <= '0;
            r_inf_valid  <= 1'b0;
            r_inf_ch     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_ch    <= '0;
`ifndef DIV_ARB_FIXED_PRIORITY_EN
            r_ptr        <= CW'(CHANNELS - 1);
`endif
        end else begin
            r_ack       <= '0;
            r_res_valid <= 1'b0;
            if (CE) begin
                // Divider takes the stage; an empty stage becomes a dummy op
                if (w_slot) begin
                    r_inf_valid  <= r_stg_valid;
                    r_inf_ch     <= r_stg_ch;
                    r_pend_valid <= r_inf_valid;
                    r_pend_ch    <= r_inf_ch;
                    r_stg_valid  <= 1'b0;
                end
                if (w_load) begin
                    r_stg_valid <= 1'b1;
                    r_stg_ch    <= w_win;
                    r_div_a     <= w_a;
                    r_div_b     <= w_b;
                    r_ack       <= w_grant;
`ifndef DIV_ARB_FIXED_PRIORITY_EN
                    r_ptr       <= w_win;
`endif
                end
                if (DIV_RES_READY && r_pend_valid) begin
                    r_res_valid <= 1'b1;
                    r_res_ch    <= r_pend_ch;
                    r_res_data  <= DIV_RESULT;
                end
            end
        end
    end

    assign ACK       = r_ack;
    assign RES_VALID = r_res_valid;
    assign RES_CH    = r_res_ch;
    assign RES_DATA  = r_res_data;
    assign DIV_CE    = CE;
    assign DIV_A     = r_div_a;
    assign DIV_B     = r_div_b;

endmodule

// File: tb/tb_divider_channel_arbiter.sv
// Directed bench for divider_channel_arbiter with a behavioural serial divider.
module tb_divider_channel_arbiter;

    localparam int CH = 2;
    localparam int OB = 30;
    localparam int RB = 25;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              CE;
    logic [CH-1:0]     REQ;
    logic [CH*OB-1:0]  REQ_A;
    logic [CH*OB-1:0]  REQ_B;
    logic [CH-1:0]     ACK;
    logic              RES_VALID;
    logic [0:0]        RES_CH;
    logic [RB-1:0]     RES_DATA;
    logic              DIV_CE;
    logic [OB-1:0]     DIV_A;
    logic [OB-1:0]     DIV_B;
    logic              DIV_IN_READY;
    logic              DIV_RES_READY;
    logic [RB-1:0]     DIV_RESULT;

    divider_channel_arbiter #(
        .CHANNELS(CH), .OPERAND_BITS(OB), .RESULT_BITS(RB)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .REQ(REQ), .REQ_A(REQ_A), .REQ_B(REQ_B), .ACK(ACK),
        .RES_VALID(RES_VALID), .RES_CH(RES_CH), .RES_DATA(RES_DATA),
        .DIV_CE(DIV_CE), .DIV_A(DIV_A), .DIV_B(DIV_B),
        .DIV_IN_READY(DIV_IN_READY), .DIV_RES_READY(DIV_RES_READY),
        .DIV_RESULT(DIV_RESULT)
    );

    always #5 CLK = ~CLK;

    // Divider model: slot every RB enabled cycles, previous result out after it
    logic [4:0]    m_cnt;
    logic          m_rdy;
    logic [RB-1:0] m_q;
    logic [RB-1:0] m_res;
    int cyc = 0;
    int last_slot = 0;
    int n_slot = 0;

    function automatic logic [RB-1:0] fdiv(input logic [OB-1:0] a, input logic [OB-1:0] b);
        longint sa;
        longint q;
        if (b == '0) return '1;
        sa = longint'($signed(a));
        q = (sa * 64'sd16777216) / longint'({34'd0, b});
        return q[RB-1:0];
    endfunction

    assign DIV_IN_READY  = (m_cnt == 5'(RB - 1));
    assign DIV_RES_READY = m_rdy;
    assign DIV_RESULT    = m_res;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RESET) begin
            m_cnt <= '0;
            m_rdy <= 1'b0;
            m_q   <= '0;
            m_res <= '0;
        end else if (CE) begin
            m_rdy <= 1'b0;
            if (DIV_IN_READY) begin
                m_cnt     <= '0;
                m_q       <= fdiv(DIV_A, DIV_B);
                m_res     <= m_q;
                m_rdy     <= 1'b1;
                last_slot <= cyc + 1;
                n_slot    <= n_slot + 1;
            end else begin
                m_cnt <= m_cnt + 5'd1;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int n_res = 0;
    int n_ack = 0;
    bit tog = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (RES_VALID) n_res++;
        if (|ACK) n_ack++;
        if (tog) CE = ~CE;
    endtask

    task automatic get_ack(input string tag, input int ch);
        int w;
        w = 0;
        do begin
            tick();
            w++;
        end while (!ACK[ch] && w < 40);
        chk({tag, "_ack_wait"}, 64'(w), 64'(1));
        chk({tag, "_ack"}, 64'(ACK), 64'(1) << ch);
        REQ[ch] = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int ch,
                            input logic [RB-1:0] exp, input int lat);
        int w;
        int n0;
        int s;
        n0 = n_slot;
        w = 0;
        while (n_slot == n0 && w < 120) begin
            tick();
            w++;
        end
        chk({tag, "_slot"}, 64'(n_slot != n0), 64'(1));
        s = last_slot;
        w = 0;
        while (!RES_VALID && w < 200) begin
            tick();
            w++;
        end
        chk({tag, "_res_valid"}, 64'(RES_VALID), 64'(1));
        chk({tag, "_res_ch"}, 64'(RES_CH), 64'(ch));
        chk({tag, "_res_data"}, 64'(RES_DATA), 64'(exp));
        chk({tag, "_latency"}, 64'(cyc - s), 64'(lat));
    endtask

    task automatic do_op(input string tag, input int ch, input logic [OB-1:0] a,
                         input logic [OB-1:0] b, input logic [RB-1:0] exp, input int lat);
        if (tog && !CE) tick();
        REQ_A[ch*OB +: OB] = a;
        REQ_B[ch*OB +: OB] = b;
        REQ[ch] = 1'b1;
        get_ack(tag, ch);
        wait_res(tag, ch, exp, lat);
    endtask

    initial begin
        int na;
        int nr;
        int ack0;
        int res0;
        int g[4];
        int rc[4];
        int rt[4];
        logic [RB-1:0] rd[4];
        int exp_g[4];
        logic [RB-1:0] exp_d[4];

        RESET = 1'b1;
        CE    = 1'b1;
        REQ   = '0;
        REQ_A = '0;
        REQ_B = '0;
        repeat (3) tick();
        RESET = 1'b0;
        chk("rst_ack", 64'(ACK), 64'(0));
        chk("rst_res_valid", 64'(RES_VALID), 64'(0));
        chk("rst_res_ch", 64'(RES_CH), 64'(0));
        chk("rst_res_data", 64'(RES_DATA), 64'(0));
        chk("rst_div_a", 64'(DIV_A), 64'(0));
        chk("rst_div_b", 64'(DIV_B), 64'(30'h3FFF_FFFF));
        chk("div_ce", 64'(DIV_CE), 64'(1));

        // Idle: only dummy ops circulate
        ack0 = n_ack;
        res0 = n_res;
        repeat (100) tick();
        chk("idle_acks", 64'(n_ack - ack0), 64'(0));
        chk("idle_results", 64'(n_res - res0), 64'(0));
        chk("idle_div_b", 64'(DIV_B), 64'(30'h3FFF_FFFF));

        do_op("ch0_pos", 0, 30'd1000, 30'd4000, 25'h040_0000, 26);
        do_op("ch1_neg", 1, 30'h3FFF_FC18, 30'd4000, 25'h1C0_0000, 26);

        // Both channels held continuously
        REQ_A = {30'h3FFF_F830, 30'd1000};
        REQ_B = {30'd4000, 30'd4000};
        REQ   = 2'b11;
        na = 0;
        nr = 0;
        for (int t = 0; t < 300 && (na < 4 || nr < 4); t++) begin
            tick();
            if (|ACK && na < 4) begin
                g[na] = int'(ACK[1]);
                na++;
            end
            if (RES_VALID && nr < 4) begin
                rc[nr] = int'(RES_CH);
                rd[nr] = RES_DATA;
                rt[nr] = cyc;
                nr++;
            end
        end
        REQ = '0;
        chk("both_n_acks", 64'(na), 64'(4));
        chk("both_n_results", 64'(nr), 64'(4));
`ifdef DIV_ARB_FIXED_PRIORITY_EN
        exp_g = '{0, 0, 0, 0};
        exp_d = '{25'h040_0000, 25'h040_0000, 25'h040_0000, 25'h040_0000};
`else
        exp_g = '{0, 1, 0, 1};
        exp_d = '{25'h040_0000, 25'h180_0000, 25'h040_0000, 25'h180_0000};
`endif
        for (int i = 0; i < 4; i++) begin
            if (i < na) chk($sformatf("both_grant%0d", i), 64'(g[i]), 64'(exp_g[i]));
            if (i < nr) begin
                chk($sformatf("both_res_ch%0d", i), 64'(rc[i]), 64'(exp_g[i]));
                chk($sformatf("both_res_data%0d", i), 64'(rd[i]), 64'(exp_d[i]));
            end
        end
        if (nr == 4) chk("both_interval", 64'(rt[2] - rt[1]), 64'(25));
        repeat (80) tick();

        // Reset 10 cycles after the capture slot, request re-raised
        REQ_A[0 +: OB] = 30'd3000;
        REQ_B[0 +: OB] = 30'd4000;
        REQ[0] = 1'b1;
        get_ack("rst_op", 0);
        na = n_slot;
        for (int t = 0; t < 60 && n_slot == na; t++) tick();
        repeat (10) tick();
        RESET  = 1'b1;
        REQ[0] = 1'b1;
        res0   = n_res;
        repeat (2) tick();
        RESET = 1'b0;
        get_ack("rst_reack", 0);
        wait_res("rst_reack", 0, 25'h0C0_0000, 26);
        chk("rst_result_count", 64'(n_res - res0), 64'(1));
        repeat (60) tick();

        // CE toggling every cycle
        tog = 1'b1;
        do_op("tog_ch0", 0, 30'd1000, 30'd4000, 25'h040_0000, 52);
        do_op("tog_ch1", 1, 30'h3FFF_FC18, 30'd4000, 25'h1C0_0000, 52);
        chk("tog_div_ce", 64'(DIV_CE), 64'(CE));
        tog = 1'b0;
        CE  = 1'b1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
